// File: rtl/ehl_gpio_arb.sv
// Round-robin / fixed-priority arbiter sharing one GPIO register update port.
// One registered write/set/clear/invert command and one-hot ack per grant.
module ehl_gpio_arb #(
   parameter int WIDTH     = 32,
   parameter int NREQ      = 4,
   parameter int FIXED_PRI = 0,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] data,
   output logic [NREQ-1:0]       ack,
   output logic                  write_reg,
   output logic [WIDTH-1:0]      data_in,
   output logic [WIDTH-1:0]      set_reg,
   output logic [WIDTH-1:0]      clr_reg,
   output logic [WIDTH-1:0]      inv_reg,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
);

   logic [NREQ-1:0]  ack_q, ack_d;
   logic             wr_q, wr_d;
   logic [WIDTH-1:0] din_q, din_d;
   logic [WIDTH-1:0] set_q, set_d;
   logic [WIDTH-1:0] clr_q, clr_d;
   logic [WIDTH-1:0] inv_q, inv_d;
   logic [IDW-1:0]   gid_q, gid_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   logic [NREQ-1:0]  elig;
   logic [IDW-1:0]   start;
   logic [IDW-1:0]   idx;
   logic             gnt_vld;
   logic [IDW-1:0]   gnt_idx;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_dat;

   // Requester acked this cycle is masked so a held req is not re-granted
   assign elig  = en ? (req & ~ack_q) : '0;
   assign start = (FIXED_PRI != 0) ? '0 : ptr_q;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(start) + k) % NREQ);
         if (!gnt_vld && elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign sel_op  = op[int'(gnt_idx)*2 +: 2];
   assign sel_dat = data[int'(gnt_idx)*WIDTH +: WIDTH];

   always_comb begin
      ack_d = '0;
      wr_d  = 1'b0;
      din_d = '0;
      set_d = '0;
      clr_d = '0;
      inv_d = '0;
      gid_d = gid_q;
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ack_d[gnt_idx] = 1'b1;
         gid_d = gnt_idx;
         if (FIXED_PRI == 0)
            ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDW'(1);
         unique case (sel_op)
            2'b00: begin
               wr_d  = 1'b1;
               din_d = sel_dat;
            end
            2'b01: set_d = sel_dat;
            2'b10: clr_d = sel_dat;
            2'b11: inv_d = sel_dat;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ack_q <= '0;
         wr_q  <= 1'b0;
         din_q <= '0;
         set_q <= '0;
         clr_q <= '0;
         inv_q <= '0;
         gid_q <= '0;
         ptr_q <= '0;
      end else begin
         ack_q <= ack_d;
         wr_q  <= wr_d;
         din_q <= din_d;
         set_q <= set_d;
         clr_q <= clr_d;
         inv_q <= inv_d;
         gid_q <= gid_d;
         ptr_q <= ptr_d;
      end
   end

   assign ack       = ack_q;
   assign write_reg = wr_q;
   assign data_in   = din_q;
   assign set_reg   = set_q;
   assign clr_reg   = clr_q;
   assign inv_reg   = inv_q;
   assign grant_id  = gid_q;
   assign busy      = (|(req & ~ack_q)) | (|ack_q);

endmodule

// File: tb/tb_ehl_gpio_arb.sv
// Directed bench for ehl_gpio_arb: one round-robin and one fixed-priority
// instance on shared stimulus, plus a model of the downstream GPIO register.
module tb_ehl_gpio_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [31:0] data;

   logic [3:0]  ack, f_ack;
   logic        wr, f_wr;
   logic [7:0]  din, setr, clrr, invr;
   logic [7:0]  f_din, f_setr, f_clrr, f_invr;
   logic [1:0]  gid, f_gid;
   logic        busy, f_busy;
   logic [32:0] cmd;
   logic [7:0]  gpio;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ehl_gpio_arb #(.WIDTH(8), .NREQ(4), .FIXED_PRI(0)) u_rr (
      .clk(clk), .reset_n(reset_n), .en(en), .req(req), .op(op),
      .data(data), .ack(ack), .write_reg(wr), .data_in(din),
      .set_reg(setr), .clr_reg(clrr), .inv_reg(invr),
      .grant_id(gid), .busy(busy)
   );

   ehl_gpio_arb #(.WIDTH(8), .NREQ(4), .FIXED_PRI(1)) u_fp (
      .clk(clk), .reset_n(reset_n), .en(en), .req(req), .op(op),
      .data(data), .ack(f_ack), .write_reg(f_wr), .data_in(f_din),
      .set_reg(f_setr), .clr_reg(f_clrr), .inv_reg(f_invr),
      .grant_id(f_gid), .busy(f_busy)
   );

   assign cmd = {wr, din, setr, clrr, invr};

   // Downstream GPIO register fed by the round-robin instance
   always @(posedge clk) begin
      if (!reset_n)
         gpio <= 8'h00;
      else if (wr)
         gpio <= din;
      else
         gpio <= ((gpio | setr) & ~clrr) ^ invr;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_rq(input int i, input logic [1:0] o, input logic [7:0] d);
      op[2*i +: 2] = o;
      data[8*i +: 8] = d;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      en = 1'b1;
      req = '0;
      op = '0;
      data = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      en = 1'b1;
      req = 4'b0000;
      op = '0;
      data = '0;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ack got=%b exp=0000", ack);
      end
      checks++;
      if (cmd !== 33'd0) begin
         errors++;
         $display("FAIL reset_cmd got=%h exp=0", cmd);
      end
      checks++;
      if (gid !== 2'd0) begin
         errors++;
         $display("FAIL reset_gid got=%0d exp=0", gid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single;
      do_reset();
      req = 4'b0001;
      set_rq(0, 2'b01, 8'h0F);
      tick();
      checks++;
      if (ack !== 4'b0001) begin
         errors++;
         $display("FAIL single_ack got=%b exp=0001", ack);
      end
      checks++;
      if (cmd !== {1'b0, 8'h00, 8'h0F, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL single_cmd got=%h exp=%h", cmd, {1'b0, 8'h00, 8'h0F, 8'h00, 8'h00});
      end
      checks++;
      if (gid !== 2'd0) begin
         errors++;
         $display("FAIL single_gid got=%0d exp=0", gid);
      end
      tick();
      checks++;
      if (ack !== 4'b0000 || cmd !== 33'd0) begin
         errors++;
         $display("FAIL single_mask got=%b/%h exp=0000/0", ack, cmd);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin;
      logic [3:0]  e_ack [5];
      logic [1:0]  e_gid [5];
      logic [32:0] e_cmd [5];
      logic [7:0]  e_gp  [5];
      e_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      e_gid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      e_cmd = '{{1'b1, 8'hA5, 8'h00, 8'h00, 8'h00},
                {1'b0, 8'h00, 8'h01, 8'h00, 8'h00},
                {1'b0, 8'h00, 8'h00, 8'h80, 8'h00},
                {1'b0, 8'h00, 8'h00, 8'h00, 8'hFF},
                {1'b1, 8'hA5, 8'h00, 8'h00, 8'h00}};
      e_gp = '{8'h00, 8'hA5, 8'hA5, 8'h25, 8'hDA};
      do_reset();
      set_rq(0, 2'b00, 8'hA5);
      set_rq(1, 2'b01, 8'h01);
      set_rq(2, 2'b10, 8'h80);
      set_rq(3, 2'b11, 8'hFF);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ack !== e_ack[i] || gid !== e_gid[i]) begin
            errors++;
            $display("FAIL rr_grant[%0d] got=%b/%0d exp=%b/%0d", i, ack, gid, e_ack[i], e_gid[i]);
         end
         checks++;
         if (cmd !== e_cmd[i]) begin
            errors++;
            $display("FAIL rr_cmd[%0d] got=%h exp=%h", i, cmd, e_cmd[i]);
         end
         checks++;
         if (gpio !== e_gp[i]) begin
            errors++;
            $display("FAIL rr_gpio[%0d] got=%h exp=%h", i, gpio, e_gp[i]);
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_fixed_pri;
      logic [3:0] ea [4];
      logic [3:0] eb [4];
      logic [3:0] er [4];
      ea = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      eb = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
      er = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
      do_reset();
      set_rq(0, 2'b01, 8'h01);
      set_rq(1, 2'b01, 8'h02);
      set_rq(2, 2'b01, 8'h04);
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (f_ack !== ea[i]) begin
            errors++;
            $display("FAIL fp_alt[%0d] got=%b exp=%b", i, f_ack, ea[i]);
         end
      end
      req = 4'b0000;
      tick();
      req = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (f_ack !== eb[i]) begin
            errors++;
            $display("FAIL fp_starve[%0d] got=%b exp=%b", i, f_ack, eb[i]);
         end
         checks++;
         if (ack !== er[i]) begin
            errors++;
            $display("FAIL rr_fair[%0d] got=%b exp=%b", i, ack, er[i]);
         end
      end
      checks++;
      if (f_gid !== 2'd1) begin
         errors++;
         $display("FAIL fp_gid got=%0d exp=1", f_gid);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_enable;
      do_reset();
      en = 1'b0;
      set_rq(1, 2'b00, 8'h12);
      set_rq(2, 2'b11, 8'h34);
      req = 4'b0110;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (ack !== 4'b0000 || cmd !== 33'd0) begin
            errors++;
            $display("FAIL en_block[%0d] got=%b/%h exp=0000/0", i, ack, cmd);
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL en_busy[%0d] got=%b exp=1", i, busy);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (ack !== 4'b0010 || cmd !== {1'b1, 8'h12, 8'h00, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL en_first got=%b/%h exp=0010/%h", ack, cmd, {1'b1, 8'h12, 8'h00, 8'h00, 8'h00});
      end
      tick();
      checks++;
      if (ack !== 4'b0100 || cmd !== {1'b0, 8'h00, 8'h00, 8'h00, 8'h34}) begin
         errors++;
         $display("FAIL en_second got=%b/%h exp=0100/%h", ack, cmd, {1'b0, 8'h00, 8'h00, 8'h00, 8'h34});
      end
      req = 4'b0000;
      tick();
      checks++;
      if (ack !== 4'b0000 || gid !== 2'd2) begin
         errors++;
         $display("FAIL gid_hold got=%b/%0d exp=0000/2", ack, gid);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      set_rq(1, 2'b00, 8'h11);
      req = 4'b0010;
      tick();
      checks++;
      if (ack !== 4'b0010) begin
         errors++;
         $display("FAIL rst_pre got=%b exp=0010", ack);
      end
      req = 4'b0000;
      tick();
      set_rq(3, 2'b01, 8'h77);
      req = 4'b1000;
      reset_n = 1'b0;
      tick();
      checks++;
      if (ack !== 4'b0000 || cmd !== 33'd0) begin
         errors++;
         $display("FAIL rst_drop got=%b/%h exp=0000/0", ack, cmd);
      end
      reset_n = 1'b1;
      set_rq(0, 2'b10, 8'h01);
      req = 4'b1001;
      tick();
      checks++;
      if (ack !== 4'b0001 || gid !== 2'd0) begin
         errors++;
         $display("FAIL rst_ptr got=%b/%0d exp=0001/0", ack, gid);
      end
      checks++;
      if (cmd !== {1'b0, 8'h00, 8'h00, 8'h01, 8'h00}) begin
         errors++;
         $display("FAIL rst_cmd got=%h exp=%h", cmd, {1'b0, 8'h00, 8'h00, 8'h01, 8'h00});
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_contention;
      do_reset();
      set_rq(1, 2'b00, 8'hC3);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      set_rq(1, 2'b01, 8'h3C);
      set_rq(2, 2'b10, 8'h3C);
      req = 4'b0110;
      tick();
      checks++;
      if (ack !== 4'b0100 || clrr !== 8'h3C) begin
         errors++;
         $display("FAIL cont_clr got=%b/%h exp=0100/3c", ack, clrr);
      end
      tick();
      checks++;
      if (ack !== 4'b0010 || setr !== 8'h3C) begin
         errors++;
         $display("FAIL cont_set got=%b/%h exp=0010/3c", ack, setr);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gpio[5:2] !== 4'b1111 || gpio !== 8'hFF) begin
         errors++;
         $display("FAIL cont_gpio got=%h exp=ff", gpio);
      end
   endtask

   task automatic test_noop_inv;
      do_reset();
      set_rq(3, 2'b11, 8'h00);
      req = 4'b1000;
      tick();
      checks++;
      if (ack !== 4'b1000 || cmd !== 33'd0 || gid !== 2'd3) begin
         errors++;
         $display("FAIL noop_inv got=%b/%h/%0d exp=1000/0/3", ack, cmd, gid);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      en = 1'b1;
      req = '0;
      op = '0;
      data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_fixed_pri();
      test_enable();
      test_reset_mid();
      test_contention();
      test_noop_inv();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
